regfile_writeback: RTL and testbench
====================================

REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

Interface
REQ-001 Parameter: DEPTH, default 4, number of entries in the write-back queue (power of two, 2..16).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 lsu_valid  input  1  load unit presents a result.
REQ-005 lsu_rd  input  5  load destination register index.
REQ-006 lsu_data  input  32  load result.
REQ-007 lsu_ready  output  1  load result accepted on the rising edge where lsu_valid and lsu_ready are both 1.
REQ-008 alu_valid  input  1  ALU presents a result.
REQ-009 alu_rd  input  5  ALU destination register index.
REQ-010 alu_data  input  32  ALU result.
REQ-011 alu_ready  output  1  ALU result accepted on the rising edge where alu_valid and alu_ready are both 1.
REQ-012 write_ena  output  1  register-file write strobe.
REQ-013 rs3  output  5  register-file write address.
REQ-014 wd3  output  32  register-file write data.
REQ-015 chk_addr  input  5  hazard/forward lookup index.
REQ-016 chk_pending  output  1  a queued write to chk_addr exists.
REQ-017 chk_data  output  32  data of the youngest queued write to chk_addr.
REQ-018 count  output  $clog2(DEPTH)+1  number of valid queue entries.

Function
REQ-019 The queue SHALL be an in-order circular FIFO of {rd, data} entries with separate head and tail pointers that wrap modulo DEPTH.
REQ-020 Readiness SHALL use the registered count only, with no same-cycle dequeue credit: free = DEPTH - count.
REQ-021 lsu_ready SHALL be 1 iff free >= 1.
REQ-022 alu_ready SHALL be 1 iff free >= 2 when lsu_valid = 1, and free >= 1 otherwise; this path is combinational from lsu_valid.
REQ-023 When both handshakes complete on the same edge, the LSU entry SHALL be enqueued first, and the ALU entry behind it.
REQ-024 An accepted result with rd = 0 SHALL complete its handshake but SHALL NOT be enqueued.
REQ-025 Whenever count > 0, write_ena SHALL be 1, with rs3/wd3 driven combinationally from the head entry. The head SHALL be popped on every rising edge where count > 0.
REQ-026 Whenever count = 0, write_ena, rs3 and wd3 SHALL all be 0.
REQ-027 Latency: a result accepted at edge N into an empty queue SHALL assert write_ena during the cycle following edge N; the register file commits it at edge N+1.
REQ-028 Pop and up to two pushes on the same edge SHALL all take effect: count_next = count + pushes - pop.
REQ-029 chk_pending SHALL be 1 iff chk_addr != 0 and at least one valid entry has rd = chk_addr. The lookup is combinational and includes the head entry.
REQ-030 chk_data SHALL come from the youngest matching entry (closest to tail), and SHALL be 0 when chk_pending = 0.
REQ-031 Throughput: sustained pushes above one per cycle SHALL stall via ready. No entry SHALL ever be overwritten or dropped (count never exceeds DEPTH).

Reset
REQ-032 While reset = 1, the following SHALL all be 0: head, tail, count, write_ena, rs3, wd3, chk_pending, chk_data.
REQ-033 While reset = 1, lsu_ready and alu_ready SHALL be 0.
REQ-034 Asserting reset mid-operation SHALL discard all queued entries, and no write_ena pulse SHALL follow deassertion.
REQ-035 After reset deasserts, the first rising edge SHALL behave as for an empty queue.

Verification
REQ-036 Single write: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF on one edge into an empty queue -> the next cycle has write_ena=1, rs3=5, wd3=0xDEADBEEF; write_ena=0 after the following edge.
REQ-037 Dual push: both valid on one edge, lsu_rd=3/0x11, alu_rd=4/0x22 -> two consecutive write cycles, rs3=3 then rs3=4.
REQ-038 x0 filter: alu_rd=0 accepted -> alu_ready=1 on that edge, count stays 0, no write_ena pulse.
REQ-039 Full/backpressure: DEPTH=4 with count=3 and both valid -> lsu_ready=1, alu_ready=0. The LSU entry alone enters, then count=3 (push 1, pop 1).
REQ-040 Forwarding: queue holds rd=7/0xA then rd=7/0xB, chk_addr=7 -> chk_pending=1, chk_data=0xB. With chk_addr=0 -> chk_pending=0, chk_data=0.
REQ-041 Async reset: assert reset between edges while count=2 -> write_ena and count drop to 0 immediately, with no write after release.

Source files
------------

// File: rtl/regfile_writeback.sv
// Write-back queue merging LSU and ALU results into a single register-file write port,
// with a combinational hazard/forward lookup over the queued writes.
module regfile_writeback #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_lsu_valid,
   input  logic [4:0]               i_lsu_rd,
   input  logic [31:0]              i_lsu_data,
   output logic                     o_lsu_ready,
   input  logic                     i_alu_valid,
   input  logic [4:0]               i_alu_rd,
   input  logic [31:0]              i_alu_data,
   output logic                     o_alu_ready,
   output logic                     o_write_ena,
   output logic [4:0]               o_rs3,
   output logic [31:0]              o_wd3,
   input  logic [4:0]               i_chk_addr,
   output logic                     o_chk_pending,
   output logic [31:0]              o_chk_data,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] CNT_TWO   = (AW+1)'(2);

   logic [4:0]    r_rd   [DEPTH];
   logic [31:0]   r_data [DEPTH];
   logic [AW-1:0] r_head;
   logic [AW-1:0] r_tail;
   logic [AW:0]   r_count;

   logic [AW:0]   w_free;
   logic          w_not_empty;
   logic          w_lsu_push;
   logic          w_alu_push;
   logic [AW-1:0] w_tail_alu;
   logic [AW:0]   w_count_next;
   logic [AW-1:0] w_idx;

   // Readiness sees only the registered count; a same-edge pop earns no credit.
   assign w_free      = DEPTH_CNT - r_count;
   assign w_not_empty = (r_count != '0);
   assign o_lsu_ready = !i_reset && (w_free != '0);
   assign o_alu_ready = !i_reset && (i_lsu_valid ? (w_free >= CNT_TWO) : (w_free != '0));

   assign w_lsu_push = i_lsu_valid && o_lsu_ready && (i_lsu_rd != 5'd0);
   assign w_alu_push = i_alu_valid && o_alu_ready && (i_alu_rd != 5'd0);
   assign w_tail_alu = w_lsu_push ? r_tail + AW'(1) : r_tail;

   assign w_count_next = r_count + (AW+1)'(w_lsu_push) + (AW+1)'(w_alu_push)
                       - (AW+1)'(w_not_empty);

   assign o_write_ena = w_not_empty;
   assign o_rs3       = w_not_empty ? r_rd[r_head] : 5'd0;
   assign o_wd3       = w_not_empty ? r_data[r_head] : 32'd0;
   assign o_count     = r_count;

   // Walk oldest to youngest so the last match seen is the youngest one.
   always_comb begin
      o_chk_pending = 1'b0;
      o_chk_data    = 32'd0;
      w_idx         = r_head;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         w_idx = r_head + AW'(k);
         if (((AW+1)'(k) < r_count) && (i_chk_addr != 5'd0) && (r_rd[w_idx] == i_chk_addr)) begin
            o_chk_pending = 1'b1;
            o_chk_data    = r_data[w_idx];
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         for (int unsigned k = 0; k < DEPTH; k++) begin
            r_rd[k]   <= 5'd0;
            r_data[k] <= 32'd0;
         end
      end else begin
         if (w_lsu_push) begin
            r_rd[r_tail]   <= i_lsu_rd;
            r_data[r_tail] <= i_lsu_data;
         end
         if (w_alu_push) begin
            r_rd[w_tail_alu]   <= i_alu_rd;
            r_data[w_tail_alu] <= i_alu_data;
         end
         r_tail  <= r_tail + AW'(w_lsu_push) + AW'(w_alu_push);
         r_head  <= r_head + AW'(w_not_empty);
         r_count <= w_count_next;
      end
   end

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed and random stimulus for regfile_writeback, checked against a queue model.
module tb_regfile_writeback;

   localparam int unsigned DEPTH = 4;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        lsu_valid = 1'b0;
   logic [4:0]  lsu_rd = '0;
   logic [31:0] lsu_data = '0;
   logic        lsu_ready;
   logic        alu_valid = 1'b0;
   logic [4:0]  alu_rd = '0;
   logic [31:0] alu_data = '0;
   logic        alu_ready;
   logic        write_ena;
   logic [4:0]  rs3;
   logic [31:0] wd3;
   logic [4:0]  chk_addr = '0;
   logic        chk_pending;
   logic [31:0] chk_data;
   logic [2:0]  count;

   ent_t q[$];
   int   total = 0;
   int   bad   = 0;

   regfile_writeback #(.DEPTH(DEPTH)) dut (
      .i_clk         (clk),
      .i_reset       (reset),
      .i_lsu_valid   (lsu_valid),
      .i_lsu_rd      (lsu_rd),
      .i_lsu_data    (lsu_data),
      .o_lsu_ready   (lsu_ready),
      .i_alu_valid   (alu_valid),
      .i_alu_rd      (alu_rd),
      .i_alu_data    (alu_data),
      .o_alu_ready   (alu_ready),
      .o_write_ena   (write_ena),
      .o_rs3         (rs3),
      .o_wd3         (wd3),
      .i_chk_addr    (chk_addr),
      .o_chk_pending (chk_pending),
      .o_chk_data    (chk_data),
      .o_count       (count)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish, observed=running required=done");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      logic        exp_pend;
      logic [31:0] exp_cdata;
      exp_pend  = 1'b0;
      exp_cdata = 32'd0;
      foreach (q[i]) begin
         if (chk_addr != 5'd0 && q[i].rd == chk_addr) begin
            exp_pend  = 1'b1;
            exp_cdata = q[i].data;
         end
      end
      check({tag, ".write_ena"}, 32'(write_ena), 32'(q.size() != 0));
      check({tag, ".rs3"}, 32'(rs3), (q.size() != 0) ? 32'(q[0].rd) : 32'd0);
      check({tag, ".wd3"}, wd3, (q.size() != 0) ? q[0].data : 32'd0);
      check({tag, ".count"}, 32'(count), 32'(q.size()));
      check({tag, ".chk_pending"}, 32'(chk_pending), 32'(exp_pend));
      check({tag, ".chk_data"}, chk_data, exp_cdata);
   endtask

   // Called at a falling edge: drives one cycle of inputs and checks the result.
   task automatic cycle(input string tag,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                        input logic av, input logic [4:0] ard, input logic [31:0] adat);
      int   free;
      logic exp_lr, exp_ar, lp, ap;
      lsu_valid = lv; lsu_rd = lrd; lsu_data = ldat;
      alu_valid = av; alu_rd = ard; alu_data = adat;
      #1;
      free   = int'(DEPTH) - q.size();
      exp_lr = (free >= 1);
      exp_ar = lv ? (free >= 2) : (free >= 1);
      check({tag, ".lsu_ready"}, 32'(lsu_ready), 32'(exp_lr));
      check({tag, ".alu_ready"}, 32'(alu_ready), 32'(exp_ar));
      lp = lv && exp_lr && (lrd != 5'd0);
      ap = av && exp_ar && (ard != 5'd0);
      @(posedge clk);
      if (q.size() > 0) void'(q.pop_front());
      if (lp) q.push_back('{rd: lrd, data: ldat});
      if (ap) q.push_back('{rd: ard, data: adat});
      @(negedge clk);
      lsu_valid = 1'b0;
      alu_valid = 1'b0;
      check_outputs(tag);
   endtask

   task automatic idle(input string tag);
      cycle(tag, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
   endtask

   initial begin
      // Reset state, with valids high so the readies are forced low by reset alone.
      lsu_valid = 1'b1;
      alu_valid = 1'b1;
      chk_addr  = 5'd3;
      #1;
      check("rst.lsu_ready", 32'(lsu_ready), 32'd0);
      check("rst.alu_ready", 32'(alu_ready), 32'd0);
      check_outputs("rst");
      lsu_valid = 1'b0;
      alu_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk_addr = 5'd0;

      // Single write.
      cycle("single", 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEAD_BEEF);
      check("single.rs3_const", 32'(rs3), 32'd5);
      idle("single_after");

      // Dual push: LSU entry ahead of ALU entry.
      cycle("dual", 1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
      check("dual.rs3_first", 32'(rs3), 32'd3);
      idle("dual_2");
      check("dual.rs3_second", 32'(rs3), 32'd4);
      idle("dual_3");

      // x0 filter.
      cycle("x0", 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55);
      idle("x0_after");

      // Fill to count=3, then both valid: only the LSU side may enter.
      cycle("fill1", 1'b1, 5'd1, 32'h101, 1'b1, 5'd2, 32'h102);
      cycle("fill2", 1'b1, 5'd6, 32'h103, 1'b1, 5'd8, 32'h104);
      check("bp.count3", 32'(count), 32'd3);
      cycle("bp", 1'b1, 5'd9, 32'h105, 1'b1, 5'd10, 32'h106);
      check("bp.count_after", 32'(count), 32'd3);
      cycle("bp_alu_only", 1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 32'h107);
      repeat (4) idle("drain");

      // Forwarding: youngest of two writes to x7 wins; x0 never reports.
      chk_addr = 5'd7;
      cycle("fwd", 1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB);
      check("fwd.chk_data_const", chk_data, 32'hB);
      chk_addr = 5'd0;
      #1;
      check_outputs("fwd_x0");
      repeat (2) idle("fwd_drain");

      // Random traffic with a small register range so lookups hit often.
      for (int i = 0; i < 300; i++) begin
         chk_addr = 5'($urandom_range(0, 7));
         cycle("rand",
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      end
      repeat (5) idle("rand_drain");

      // Asynchronous reset between edges with two entries queued.
      chk_addr = 5'd10;
      cycle("prerst", 1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hAA);
      check("prerst.count", 32'(count), 32'd2);
      #2;
      reset     = 1'b1;
      lsu_valid = 1'b1;
      alu_valid = 1'b1;
      #1;
      q.delete();
      check("midrst.lsu_ready", 32'(lsu_ready), 32'd0);
      check("midrst.alu_ready", 32'(alu_ready), 32'd0);
      check_outputs("midrst");
      lsu_valid = 1'b0;
      alu_valid = 1'b0;
      #1;
      reset = 1'b0;
      @(negedge clk);
      check_outputs("postrst");
      repeat (3) idle("postrst_idle");
      cycle("postrst_push", 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h1234);
      idle("postrst_end");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
